// File: rtl/minority_arbiter.sv
// Round-robin arbiter that shares one 3-input minority evaluator among N_REQ
// requesters. Each result is tagged with its requester and held until the downstream port accepts it.
module minority_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [3*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 res_valid,
  output logic                 res_f,
  output logic [ID_W-1:0]      res_id,
  input  logic                 res_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EVAL, HOLD} state_t;

  state_t          state, state_nxt;
  logic [ID_W-1:0] ptr, tag, grant_idx, cand;
  logic [2:0]      op, op_sel;
  logic            grant_found, accept;
  int              idx;

  // Search order is ptr, ptr+1, ... wrapping at N_REQ, so the requester
  // served last always ends up with the lowest priority.
  always_comb begin
    // NOTE: defaults come first so that no path through this block infers a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    cand        = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = ID_W'(idx);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) op_sel = req_data[3*i +: 3];
    end
  end

  assign accept = (state == IDLE) && grant_found && !rst;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EVAL;
      EVAL:    state_nxt = HOLD;
      HOLD:    if (res_valid && res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      op        <= '0;
      tag       <= '0;
      res_valid <= 1'b0;
      res_f     <= 1'b0;
      res_id    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op  <= op_sel;
        tag <= grant_idx;
      end
      if (state == EVAL) begin
        res_f     <= ~((op[2] & op[1]) | (op[1] & op[0]) | (op[0] & op[2]));
        res_id    <= tag;
        res_valid <= 1'b1;
      end
      if (state == HOLD && res_valid && res_ready) begin
        res_valid <= 1'b0;
        ptr       <= (tag == ID_W'(N_REQ - 1)) ? '0 : tag + 1'b1;
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_minority_arbiter.sv
// Directed bench for minority_arbiter: stimulus pushes expected {id,f} into a
// scoreboard queue, and a monitor pops and compares on every output handshake.
module tb_minority_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  typedef struct {
    int id;
    bit f;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req_valid;
  logic [3*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic               res_valid;
  logic               res_f;
  logic [ID_W-1:0]    res_id;
  logic               res_ready;
  logic               busy;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  minority_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_f     (res_f),
    .res_id    (res_id),
    .res_ready (res_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int id, input bit f);
    exp_t e;
    e.id = id;
    e.f  = f;
    exp_q.push_back(e);
  endtask

  // Starts at a negedge in IDLE with res_ready=1; returns at the next IDLE negedge.
  task automatic txn(input int r, input logic [2:0] d, input bit exp_f);
    req_valid = N_REQ'(1 << r);
    req_data  = '0;
    req_data[3*r +: 3] = d;
    #1;
    check("grant", 32'(req_ready), 32'(1 << r));
    push(r, exp_f);
    cyc(1);
    req_valid = '0;
    #1;
    check("eval_busy", 32'(busy), 32'd1);
    check("eval_no_result", 32'(res_valid), 32'd0);
    cyc(1);
    #1;
    check("latency_res_valid", 32'(res_valid), 32'd1);
    cyc(1);
    #1;
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // Monitor: compares whenever the output handshake is about to occur.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_result: got id %0d f %0b, expected none", res_id, res_f);
        end else begin
          e = exp_q.pop_front();
          check("res_id", 32'(res_id), 32'(e.id));
          check("res_f", 32'(res_f), 32'(e.f));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]          tt_f;
    logic [3:0]          fair_f;
    logic [3*N_REQ-1:0]  fair_data;
    tt_f      = 8'b0001_0111;                 // f for operands 7..0
    fair_data = {3'b100, 3'b101, 3'b011, 3'b000};
    fair_f    = 4'b1001;                      // f for requesters 3..0

    rst       = 1'b1;
    res_ready = 1'b1;
    req_valid = '1;
    req_data  = '0;
    cyc(1);
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_res_f", 32'(res_f), 32'd0);
    check("rst_res_id", 32'(res_id), 32'd0);
    rst       = 1'b0;
    req_valid = '0;
    cyc(1);

    // Single requests; ptr ends at 1 but requester 0 is the only one asking.
    txn(0, 3'b001, 1'b1);
    txn(0, 3'b011, 1'b0);

    // Full truth table on requester 2; ptr ends at 3.
    for (int v = 0; v < 8; v++) txn(2, 3'(v), tt_f[v]);

    // Reset during EVAL: grant 0 (search 3 then 0), no result may follow.
    req_valid = 4'b0001;
    req_data  = '0;
    #1;
    check("pre_reset_grant", 32'(req_ready), 32'b0001);
    cyc(1);
    req_valid = '1;
    #1;
    check("pre_reset_busy", 32'(busy), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_res_valid", 32'(res_valid), 32'd0);
    check("async_rst_req_ready", 32'(req_ready), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    cyc(1);
    rst       = 1'b0;
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      #1;
      check("no_stale_result", 32'(res_valid), 32'd0);
    end

    // Fairness from ptr=0: grants 0,1,2,3,0,1,2, one every 3 cycles.
    req_valid = '1;
    req_data  = fair_data;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("rr_grant", 32'(req_ready), 32'(1 << (i % 4)));
      push(i % 4, fair_f[i % 4]);
      cyc(3);
    end

    // Wrap and skip from ptr=3 with requesters 1 and 2 asking.
    req_valid = 4'b0110;
    #1;
    check("skip_grant1", 32'(req_ready), 32'b0010);
    push(1, 1'b0);
    cyc(3);
    #1;
    check("skip_grant2", 32'(req_ready), 32'b0100);
    push(2, 1'b0);
    cyc(3);
    req_valid = 4'b1001;
    #1;
    check("ptr_is_3", 32'(req_ready), 32'b1000);
    push(3, 1'b1);
    cyc(1);
    req_valid = '0;
    cyc(2);

    // Backpressure from ptr=0: requester 1, operand 010 -> f=1, held 5 cycles.
    res_ready = 1'b0;
    req_valid = 4'b0010;
    req_data  = 12'b000_000_010_000;
    #1;
    check("bp_grant", 32'(req_ready), 32'b0010);
    push(1, 1'b1);
    cyc(1);
    req_valid = '1;
    #1;
    check("bp_eval_req_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      #1;
      check("bp_res_valid", 32'(res_valid), 32'd1);
      check("bp_res_f", 32'(res_f), 32'd1);
      check("bp_res_id", 32'(res_id), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
    end
    res_ready = 1'b1;
    cyc(1);
    #1;
    check("bp_ptr_after", 32'(req_ready), 32'b0100);
    req_valid = '0;

    cyc(3);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
